// File: rtl/train_dispatch_scheduler.sv
// Round-robin train dispatcher: grants one depot train at a time to a station whose
// limit exceeds trains present plus trains already en route, via a valid/ready offer.
module train_dispatch_scheduler #(
    parameter int N       = 4,
    parameter int CW      = 8,
    parameter int IW      = 2,
    parameter int HOLDOFF = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N*CW-1:0] l_flat,
    input  logic [N*CW-1:0] c_flat,
    input  logic [N-1:0]    arrive,
    input  logic            train_avail,
    input  logic            dispatch_ready,
    output logic            dispatch_valid,
    output logic [IW-1:0]   dispatch_id,
    output logic [N*CW-1:0] pending_flat,
    output logic [31:0]     dispatch_count
);

    // state   | meaning
    // S_IDLE  | looking for an eligible station while enabled and a train is available
    // S_OFFER | offer of latched id held on dispatch_valid until the depot accepts
    // S_HOLD  | settling gap after an accept, hold_q counts down to 0
    typedef enum logic [1:0] {S_IDLE, S_OFFER, S_HOLD} state_t;

    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    state_t          state_q, state_d;
    logic            valid_q, valid_d;
    logic [IW-1:0]   id_q, id_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [31:0]     count_q, count_d;
    logic [CW-1:0]   pend_q [N];
    logic [CW-1:0]   pend_d [N];

    logic [N-1:0]    elig;
    logic            grant_any;
    logic [IW-1:0]   grant_id;
    logic            accept;
    logic [N-1:0]    inc_v;
    logic [N-1:0]    dec_v;

    // Compare in CW+1 bits so C + pend can never wrap into a false deficit.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = {1'b0, l_flat[i*CW +: CW]} >
                      ({1'b0, c_flat[i*CW +: CW]} + {1'b0, pend_q[i]});
        end
    end

    // Scan downward so the station closest after ptr is the last (winning) assignment.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr_q) + k) % N;
            if (elig[idx]) begin
                grant_any = 1'b1;
                grant_id  = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        count_d = count_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en && train_avail && grant_any) begin
                    state_d = S_OFFER;
                    valid_d = 1'b1;
                    id_d    = grant_id;
                end
            end
            S_OFFER: begin
                if (dispatch_ready) begin
                    accept  = 1'b1;
                    valid_d = 1'b0;
                    ptr_d   = id_q;
                    count_d = count_q + 32'd1;
                    if (HOLDOFF == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                        hold_d  = HW'(HOLDOFF - 1);
                    end
                end
            end
            S_HOLD: begin
                if (hold_q == '0) state_d = S_IDLE;
                else              hold_d  = hold_q - HW'(1);
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Accept and arrival on the same station cancel; arrivals with nothing pending are dropped.
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int i = 0; i < N; i++) begin
            pend_d[i] = pend_q[i];
            inc_v[i]  = accept && (id_q == IW'(i));
            dec_v[i]  = arrive[i] && (pend_q[i] != '0);
            if (inc_v[i] && !dec_v[i]) begin
                if (pend_q[i] != '1) pend_d[i] = pend_q[i] + CW'(1);
            end else if (!inc_v[i] && dec_v[i]) begin
                pend_d[i] = pend_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
            ptr_q   <= IW'(N - 1);
            hold_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < N; i++) pend_q[i] <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            count_q <= count_d;
            for (int i = 0; i < N; i++) pend_q[i] <= pend_d[i];
        end
    end

    always_comb begin
        pending_flat = '0;
        for (int i = 0; i < N; i++) pending_flat[i*CW +: CW] = pend_q[i];
    end

    assign dispatch_valid = valid_q;
    assign dispatch_id    = id_q;
    assign dispatch_count = count_q;

endmodule

// File: doc/train_dispatch_scheduler.md
# train_dispatch_scheduler

Sequential dispatcher for N dropoff stations that share one depot of loaded trains. Each cycle it compares every station's requested train limit L against the trains it already has (C) plus trains dispatched but not yet arrived. It grants round-robin among stations in deficit and offers each grant on a valid/ready handshake to the depot departure logic. It sits between the per-station L/C circuits and the depot stop, so several stations never over-claim the same train.

## Interface
Parameters:
- N, 4, number of dropoff stations (2..16)
- CW, 8, width of per-station L, C and pending counts
- IW, 2, width of station id (≥ clog2(N))
- HOLDOFF, 4, cycles idle after each accepted dispatch so station C/L can settle (0 allowed)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  scheduling enable
- l_flat  in  N*CW  station i train limit L at bits [i*CW +: CW]
- c_flat  in  N*CW  station i trains present/queued C, same packing
- arrive  in  N  one-cycle pulse: a dispatched train reached station i
- train_avail  in  1  depot holds a loaded train (level)
- dispatch_ready  in  1  depot accepts the current offer
- dispatch_valid  out  1  offer pending
- dispatch_id  out  IW  station the offered train goes to
- pending_flat  out  N*CW  trains dispatched to station i and not yet arrived
- dispatch_count  out  32  total accepted dispatches, wraps at 2^32

## Operation
- Deficit: elig[i] = (L[i] > C[i] + pend[i]), with the sum computed in CW+1 bits so it cannot overflow.
- FSM states: IDLE, OFFER, HOLD.
- IDLE: if en & train_avail & |elig, latch the grant and go to OFFER. Otherwise stay in IDLE.
- Grant: first eligible index scanning upward from ptr+1, wrapping modulo N. ptr is the last accepted id; it resets to N-1, so the first scan starts at 0.
- OFFER: dispatch_valid=1 and dispatch_id holds the latched id. The offer is never retracted or changed, even if en, train_avail or elig drop. On dispatch_valid & dispatch_ready:
  - pend[id] +1, saturating at 2^CW-1
  - ptr ← id
  - dispatch_count +1
  - next state is HOLD, or IDLE if HOLDOFF=0
- HOLD: a down-counter loads HOLDOFF-1 on entry and returns to IDLE when it reaches 0. No new offers are made during HOLD.
- arrive[i]: pend[i] −1. It is ignored when pend[i]=0. It is processed in every state.
- If accept and arrive hit the same station in the same cycle, pend is unchanged. If they hit different stations, both updates apply.
- Multiple arrive bits in one cycle are all applied.
- en=0 only blocks the IDLE→OFFER transition. HOLD still counts down.

## Timing
- Reset values: dispatch_valid 0, dispatch_id 0, pending_flat 0, dispatch_count 0, state IDLE, ptr N-1, hold counter 0.
- Asserting rst_n low in any state clears everything asynchronously. An in-flight offer is dropped, with no accept counted.
- Offer latency: if the IDLE condition is true at edge k, dispatch_valid is high after edge k.
- If dispatch_ready is already high, the accept takes effect at edge k+1, and pend/dispatch_count are updated after k+1.
- Minimum spacing between accepts is HOLDOFF+2 edges, or 2 edges when HOLDOFF=0.
- elig is evaluated combinationally from current inputs and pend in IDLE only.
- pending_flat and dispatch_count are registered outputs. dispatch_valid and dispatch_id come directly from registers.

## Test plan
- Single deficit: N=4, L={0,3,0,0}, C=0, train_avail=1, ready=1 → three dispatches, all id=1, spaced 6 edges apart (HOLDOFF=4), then pend[1]=3 and no further valid.
- Round-robin: L={1,1,1,1}, C=0 → ids 0,1,2,3 in order, dispatch_count=4. Then pulse arrive[2] while L[2]=2 → next id=2.
- Backpressure: hold ready=0 for 10 cycles mid-offer while dropping train_avail and en → valid stays high with a stable id. Raising ready gives exactly one accept.
- Simultaneous: accept to id=1 in the same cycle as arrive[1] with pend[1]=2 → pend[1] stays 2. arrive[0] with pend[0]=0 → stays 0.
- Saturation: CW=2, L=3, C=0, with arrivals suppressed → pend stops at 3 and no eligibility remains. A wider L in CW+1 compare test: L=3, C=3, pend=3 → not eligible, no wrap.
- Reset mid-offer: drop rst_n while valid=1 and pend[3]=2 → immediately valid=0, pend all 0, dispatch_count 0. After release, the first grant starts scanning from id 0.
